// File: rtl/vram_arbiter.sv
// vram_arbiter -- shares one single-port synchronous video RAM between a
// display fetcher and a CPU port.
//
// The display normally has priority. A CPU request that is denied for
// MAX_WAIT consecutive cycles is forced through, so the CPU cannot starve.
// RAM read data comes back one cycle after ram_en. The matching response
// strobe (disp_valid or cpu_ack) is registered so that it lines up with
// that data.
//
// Ports
//   clk, rstn                        clock, async active-low reset
//   disp_req/disp_addr -> disp_gnt   display word-read request and accept
//   disp_valid/disp_data             display read response (pulse)
//   cpu_req/we/addr/wdata/wstrb      CPU access, held until cpu_ack
//   cpu_ack/cpu_rdata                CPU completion (pulse), read data
//   ram_en/we/addr/wdata, ram_rdata  RAM command and read data
module vram_arbiter #(
  parameter int AW       = 17,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            disp_req,
  input  logic [AW-1:0]   disp_addr,
  output logic            disp_gnt,
  output logic            disp_valid,
  output logic [DW-1:0]   disp_data,
  input  logic            cpu_req,
  input  logic            cpu_we,
  input  logic [AW-1:0]   cpu_addr,
  input  logic [DW-1:0]   cpu_wdata,
  input  logic [DW/8-1:0] cpu_wstrb,
  output logic            cpu_ack,
  output logic [DW-1:0]   cpu_rdata,
  output logic            ram_en,
  output logic [DW/8-1:0] ram_we,
  output logic [AW-1:0]   ram_addr,
  output logic [DW-1:0]   ram_wdata,
  input  logic [DW-1:0]   ram_rdata
);

  localparam int          SW   = DW / 8;
  localparam logic [7:0]  MAXW = MAX_WAIT[7:0];

  typedef enum logic {IDLE, CPU_RESP} state_t;

  state_t          state, state_nxt;
  logic [7:0]      wait_cnt, wait_nxt;
  logic            cpu_elig, force_cpu, cpu_gnt, disp_gnt_i;
  logic            ram_en_i;
  logic [SW-1:0]   ram_we_i;

  // The grant decision feeds the response flops. rstn only gates the copies
  // that leave the block, so reset never enters the flop data paths.
  always_comb begin
    cpu_elig   = (state == IDLE) && cpu_req;
    force_cpu  = cpu_elig && (wait_cnt == MAXW);
    cpu_gnt    = cpu_elig && (force_cpu || !disp_req);
    disp_gnt_i = disp_req && !force_cpu;

    ram_en_i  = 1'b0;
    ram_we_i  = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (cpu_gnt) begin
      ram_en_i  = 1'b1;
      ram_we_i  = cpu_we ? cpu_wstrb : '0;
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
    end else if (disp_gnt_i) begin
      ram_en_i  = 1'b1;
      ram_addr  = disp_addr;
    end

    // CPU_RESP lasts exactly one cycle. The CPU is never eligible in that
    // cycle, so a request still held high cannot be issued a second time.
    state_nxt = cpu_gnt ? CPU_RESP : IDLE;

    wait_nxt = wait_cnt;
    if (!cpu_req || cpu_gnt)
      wait_nxt = '0;
    else if (cpu_elig && wait_cnt != MAXW)
      wait_nxt = wait_cnt + 8'd1;
  end

  assign disp_gnt = rstn & disp_gnt_i;
  assign ram_en   = rstn & ram_en_i;
  assign ram_we   = rstn ? ram_we_i : '0;

  // Read data passes straight from the RAM. It is zeroed when no response
  // is presented.
  assign disp_data = disp_valid ? ram_rdata : '0;
  assign cpu_rdata = cpu_ack    ? ram_rdata : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      disp_valid <= 1'b0;
      cpu_ack    <= 1'b0;
    end else begin
      state      <= state_nxt;
      wait_cnt   <= wait_nxt;
      disp_valid <= disp_gnt_i && !cpu_gnt;
      cpu_ack    <= cpu_gnt;
    end
  end

endmodule
